mem_stage: RTL and testbench

Memory-access stage of the 5-stage MIPS pipeline. Sits between the EX/MEM latch and `Latch_MEM_WB`. It owns the data memory, performs byte/halfword/word loads (sign- or zero-extended) and stores, and forwards the writeback controls unchanged. It also provides a debug read port for the debug unit and a sticky misaligned-access flag.

---
 rtl/mem_stage.sv | 189 ++++++++++++++++++
 tb/tb_mem_stage.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 5-stage MIPS pipeline.
//
// Sits between the EX/MEM latch and Latch_MEM_WB. Owns the data memory,
// performs byte/halfword/word loads (sign- or zero-extended) and
// byte/halfword/word stores, and forwards the writeback controls unchanged.
// It also provides a debug read port, a sticky misaligned-access flag and a
// count of committed stores.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset (control only)
//   i_step              pipeline advance enable; no state update when low
//   i_ALU_res           byte address of the access (also passed through)
//   i_write_data        store data (rt value)
//   is_MemRead          load request
//   is_MemWrite         store request
//   i_size              00 byte, 01 halfword, 1x word
//   i_unsigned          1 = zero-extend loads, 0 = sign-extend
//   i_addr_reg_dst, i_pc_to_reg, is_RegWrite, is_MemtoReg, is_write_pc,
//   is_stop_pipe        writeback controls, forwarded combinationally
//   i_debug_addr        word index for the debug read port
//   o_output_mem        extended load data (0 when no load or misaligned)
//   o_ALU_res, o_addr_reg_dst, o_pc_to_reg, os_RegWrite, os_MemtoReg,
//   os_write_pc, os_stop_pipe   combinational copies of the matching inputs
//   o_debug_data        word at i_debug_addr
//   o_misaligned        sticky flag, set by the first misaligned access
//   o_misaligned_addr   address of that first misaligned access
//   o_store_count       number of committed stores (wraps at 2^32)
module mem_stage #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_step,
  input  logic [31:0]   i_ALU_res,
  input  logic [31:0]   i_write_data,
  input  logic          is_MemRead,
  input  logic          is_MemWrite,
  input  logic [1:0]    i_size,
  input  logic          i_unsigned,
  input  logic [4:0]    i_addr_reg_dst,
  input  logic [31:0]   i_pc_to_reg,
  input  logic          is_RegWrite,
  input  logic          is_MemtoReg,
  input  logic          is_write_pc,
  input  logic          is_stop_pipe,
  input  logic [AW-1:0] i_debug_addr,
  output logic [31:0]   o_output_mem,
  output logic [31:0]   o_ALU_res,
  output logic [4:0]    o_addr_reg_dst,
  output logic [31:0]   o_pc_to_reg,
  output logic          os_RegWrite,
  output logic          os_MemtoReg,
  output logic          os_write_pc,
  output logic          os_stop_pipe,
  output logic [31:0]   o_debug_data,
  output logic          o_misaligned,
  output logic [31:0]   o_misaligned_addr,
  output logic [31:0]   o_store_count
);

  // Select the addressed byte/half/word of a memory word and extend it.
  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  off,
                                              input logic        uns);
    logic        [7:0]  b;
    logic        [15:0] h;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    logic        [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h  = off[1] ? word[31:16] : word[15:0];
    sb = b;
    sh = h;
    if (size[1]) begin
      r = word;
    end else if (size[0]) begin
      r = uns ? 32'(h) : 32'(sh);
    end else begin
      r = uns ? 32'(b) : 32'(sb);
    end
    return r;
  endfunction

  // Merge store data into the old word; bytes outside the access are kept.
  function automatic logic [31:0] merge_store(input logic [31:0] old_word,
                                              input logic [31:0] data,
                                              input logic [1:0]  size,
                                              input logic [1:0]  off);
    logic [3:0]  lanes;
    logic [31:0] wdata;
    logic [31:0] bitmask;
    if (size[1]) begin
      lanes = 4'b1111;
      wdata = data;
    end else if (size[0]) begin
      lanes = off[1] ? 4'b1100 : 4'b0011;
      wdata = {2{data[15:0]}};
    end else begin
      lanes = 4'b0001 << off;
      wdata = {4{data[7:0]}};
    end
    bitmask = {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
    return (old_word & ~bitmask) | (wdata & bitmask);
  endfunction

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] widx;
  logic [1:0]    boff;
  logic          is_half;
  logic          is_word;
  logic          misaligned;
  logic          store_en;
  logic [31:0]   rd_word;

  logic          mis_q, mis_d;
  logic [31:0]   mis_addr_q, mis_addr_d;
  logic [31:0]   store_cnt_q, store_cnt_d;

  // Address decode and access classification (combinational)
  assign widx    = i_ALU_res[AW+1:2];
  assign boff    = i_ALU_res[1:0];
  assign is_word = i_size[1];            // 10 (reserved) behaves as word
  assign is_half = (i_size == 2'b01);

  assign misaligned = (is_MemRead | is_MemWrite) &
                      ((is_half & boff[0]) | (is_word & (boff != 2'b00)));
  assign store_en   = i_step & is_MemWrite & ~misaligned;

  // Reads see the array before any write on the coming edge, which gives
  // read-before-write for simultaneous load+store and for the debug port.
  assign rd_word      = mem_q[widx];
  assign o_debug_data = mem_q[i_debug_addr];
  assign o_output_mem = (is_MemRead & ~misaligned) ?
                        extend_load(rd_word, i_size, boff, i_unsigned) : 32'd0;

  assign o_ALU_res      = i_ALU_res;
  assign o_addr_reg_dst = i_addr_reg_dst;
  assign o_pc_to_reg    = i_pc_to_reg;
  assign os_RegWrite    = is_RegWrite;
  assign os_MemtoReg    = is_MemtoReg;
  assign os_write_pc    = is_write_pc;
  assign os_stop_pipe   = is_stop_pipe;

  // Commit edge: data memory (not reset, contents survive rst)
  always_ff @(posedge clk) begin
    if (store_en) begin
      mem_q[widx] <= merge_store(rd_word, i_write_data, i_size, boff);
    end
  end

  // Commit edge: status next-state
  always_comb begin
    mis_d       = mis_q;
    mis_addr_d  = mis_addr_q;
    store_cnt_d = store_cnt_q;
    if (store_en) begin
      store_cnt_d = store_cnt_q + 32'd1;
    end
    // Only the first misaligned access is recorded until the next reset.
    if (i_step & misaligned & ~mis_q) begin
      mis_d      = 1'b1;
      mis_addr_d = i_ALU_res;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mis_q       <= 1'b0;
      mis_addr_q  <= 32'd0;
      store_cnt_q <= 32'd0;
    end else begin
      mis_q       <= mis_d;
      mis_addr_q  <= mis_addr_d;
      store_cnt_q <= store_cnt_d;
    end
  end

  assign o_misaligned      = mis_q;
  assign o_misaligned_addr = mis_addr_q;
  assign o_store_count     = store_cnt_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  localparam int DEPTH = 64;
  localparam int AW    = $clog2(DEPTH);
  localparam int NB    = 4 * DEPTH;

  logic          clk;
  logic          rst;
  logic          i_step;
  logic [31:0]   i_ALU_res;
  logic [31:0]   i_write_data;
  logic          is_MemRead;
  logic          is_MemWrite;
  logic [1:0]    i_size;
  logic          i_unsigned;
  logic [4:0]    i_addr_reg_dst;
  logic [31:0]   i_pc_to_reg;
  logic          is_RegWrite;
  logic          is_MemtoReg;
  logic          is_write_pc;
  logic          is_stop_pipe;
  logic [AW-1:0] i_debug_addr;
  logic [31:0]   o_output_mem;
  logic [31:0]   o_ALU_res;
  logic [4:0]    o_addr_reg_dst;
  logic [31:0]   o_pc_to_reg;
  logic          os_RegWrite;
  logic          os_MemtoReg;
  logic          os_write_pc;
  logic          os_stop_pipe;
  logic [31:0]   o_debug_data;
  logic          o_misaligned;
  logic [31:0]   o_misaligned_addr;
  logic [31:0]   o_store_count;

  int errors = 0;
  int checks = 0;

  // Reference model: byte-addressed memory plus status
  logic [7:0]  mem_m [NB];
  logic [31:0] cnt_m;
  logic        flag_m;
  logic [31:0] maddr_m;

  mem_stage #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .i_step(i_step), .i_ALU_res(i_ALU_res),
    .i_write_data(i_write_data), .is_MemRead(is_MemRead),
    .is_MemWrite(is_MemWrite), .i_size(i_size), .i_unsigned(i_unsigned),
    .i_addr_reg_dst(i_addr_reg_dst), .i_pc_to_reg(i_pc_to_reg),
    .is_RegWrite(is_RegWrite), .is_MemtoReg(is_MemtoReg),
    .is_write_pc(is_write_pc), .is_stop_pipe(is_stop_pipe),
    .i_debug_addr(i_debug_addr), .o_output_mem(o_output_mem),
    .o_ALU_res(o_ALU_res), .o_addr_reg_dst(o_addr_reg_dst),
    .o_pc_to_reg(o_pc_to_reg), .os_RegWrite(os_RegWrite),
    .os_MemtoReg(os_MemtoReg), .os_write_pc(os_write_pc),
    .os_stop_pipe(os_stop_pipe), .o_debug_data(o_debug_data),
    .o_misaligned(o_misaligned), .o_misaligned_addr(o_misaligned_addr),
    .o_store_count(o_store_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int nbytes(input logic [1:0] s);
    if (s == 2'b00) return 1;
    if (s == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit mis_m(input logic [31:0] a, input logic [1:0] s,
                               input logic rd, input logic wr);
    return (rd || wr) && ((a % nbytes(s)) != 0);
  endfunction

  function automatic logic [31:0] load_m(input logic [31:0] a,
                                         input logic [1:0] s, input logic uns);
    int     n;
    int     base;
    longint v;
    n    = nbytes(s);
    base = int'(a % NB);
    v    = 0;
    for (int k = 0; k < n; k++) v = v + (longint'(mem_m[base + k]) << (8 * k));
    if (!uns && n < 4 && ((v >> (8 * n - 1)) & 1) == 1)
      v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  function automatic logic [31:0] word_m(input int idx);
    return {mem_m[4*idx+3], mem_m[4*idx+2], mem_m[4*idx+1], mem_m[4*idx]};
  endfunction

  task automatic set_in(input logic [31:0] a, input logic [31:0] wd,
                        input logic rd, input logic wr, input logic [1:0] s,
                        input logic uns, input logic step);
    i_ALU_res    = a;
    i_write_data = wd;
    is_MemRead   = rd;
    is_MemWrite  = wr;
    i_size       = s;
    i_unsigned   = uns;
    i_step       = step;
  endtask

  // One clock edge; the model applies the same edge's effects.
  task automatic commit();
    logic [31:0] a;
    bit          m;
    a = i_ALU_res;
    m = mis_m(a, i_size, is_MemRead, is_MemWrite);
    @(posedge clk);
    if (!rst && i_step) begin
      if (is_MemWrite && !m) begin
        for (int k = 0; k < nbytes(i_size); k++)
          mem_m[int'(a % NB) + k] = 8'((i_write_data >> (8 * k)) & 32'hFF);
        cnt_m = cnt_m + 32'd1;
      end
      if (m && !flag_m) begin
        flag_m  = 1'b1;
        maddr_m = a;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    // async assert away from any edge; status must clear with no clock
    rst = 1'b1;
    #1;
    cnt_m = 0; flag_m = 1'b0; maddr_m = 0;
    checks++; if (o_store_count !== 32'd0) begin errors++;
      $display("FAIL reset_count: got %h expected 0", o_store_count); end
    checks++; if (o_misaligned !== 1'b0) begin errors++;
      $display("FAIL reset_flag: got %b expected 0", o_misaligned); end
    checks++; if (o_misaligned_addr !== 32'd0) begin errors++;
      $display("FAIL reset_addr: got %h expected 0", o_misaligned_addr); end
    i_debug_addr = AW'(4);
    #1;
    checks++; if (o_debug_data !== word_m(4)) begin errors++;
      $display("FAIL reset_mem_keep: got %h expected %h", o_debug_data, word_m(4)); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_word();
    set_in(32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1);
    i_debug_addr = AW'(4);
    #1;
    checks++; if (o_debug_data !== 32'h0) begin errors++;
      $display("FAIL word_pre_commit: got %h expected 0", o_debug_data); end
    commit();
    set_in(32'h10, 32'h0, 1'b1, 1'b0, 2'b11, 1'b0, 1'b1);
    #1;
    checks++; if (o_output_mem !== 32'hDEADBEEF) begin errors++;
      $display("FAIL word_load: got %h expected deadbeef", o_output_mem); end
    checks++; if (o_debug_data !== 32'hDEADBEEF) begin errors++;
      $display("FAIL word_debug: got %h expected deadbeef", o_debug_data); end
    checks++; if (o_store_count !== 32'd1) begin errors++;
      $display("FAIL word_count: got %0d expected 1", o_store_count); end
  endtask

  task automatic test_byte();
    // load and store together: load returns the byte before the store
    set_in(32'h11, 32'h0000007F, 1'b1, 1'b1, 2'b00, 1'b1, 1'b1);
    #1;
    checks++; if (o_output_mem !== 32'h000000BE) begin errors++;
      $display("FAIL byte_rw_old: got %h expected 000000be", o_output_mem); end
    commit();
    set_in(32'h13, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
    #1;
    checks++; if (o_debug_data !== 32'hDEAD7FEF) begin errors++;
      $display("FAIL byte_store: got %h expected dead7fef", o_debug_data); end
    checks++; if (o_output_mem !== 32'hFFFFFFDE) begin errors++;
      $display("FAIL byte_load_s: got %h expected ffffffde", o_output_mem); end
    i_unsigned = 1'b1;
    #1;
    checks++; if (o_output_mem !== 32'h000000DE) begin errors++;
      $display("FAIL byte_load_u: got %h expected 000000de", o_output_mem); end
  endtask

  task automatic test_half();
    set_in(32'h10, 32'h8001ABCD, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1);
    commit();
    set_in(32'h12, 32'h0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1);
    #1;
    checks++; if (o_output_mem !== 32'hFFFF8001) begin errors++;
      $display("FAIL half_load_s: got %h expected ffff8001", o_output_mem); end
    i_unsigned = 1'b1;
    #1;
    checks++; if (o_output_mem !== 32'h00008001) begin errors++;
      $display("FAIL half_load_u: got %h expected 00008001", o_output_mem); end
    i_ALU_res = 32'h10;
    #1;
    checks++; if (o_output_mem !== 32'h0000ABCD) begin errors++;
      $display("FAIL half_load_lo: got %h expected 0000abcd", o_output_mem); end
    set_in(32'h12, 32'hFFFF1234, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1);
    commit();
    checks++; if (o_debug_data !== 32'h1234ABCD) begin errors++;
      $display("FAIL half_store: got %h expected 1234abcd", o_debug_data); end
  endtask

  task automatic test_misaligned();
    logic [31:0] cnt0;
    cnt0 = o_store_count;
    checks++; if (o_misaligned !== 1'b0) begin errors++;
      $display("FAIL mis_clear: got %b expected 0", o_misaligned); end
    set_in(32'h13, 32'h55555555, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1);
    commit();
    checks++; if (o_debug_data !== 32'h1234ABCD) begin errors++;
      $display("FAIL mis_suppress: got %h expected 1234abcd", o_debug_data); end
    checks++; if (o_misaligned !== 1'b1) begin errors++;
      $display("FAIL mis_flag: got %b expected 1", o_misaligned); end
    checks++; if (o_misaligned_addr !== 32'h13) begin errors++;
      $display("FAIL mis_addr: got %h expected 00000013", o_misaligned_addr); end
    checks++; if (o_store_count !== cnt0) begin errors++;
      $display("FAIL mis_count: got %0d expected %0d", o_store_count, cnt0); end
    set_in(32'h23, 32'h0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1);
    #1;
    checks++; if (o_output_mem !== 32'h0) begin errors++;
      $display("FAIL mis_load_zero: got %h expected 0", o_output_mem); end
    set_in(32'h22, 32'h0, 1'b1, 1'b0, 2'b11, 1'b0, 1'b1);
    commit();
    checks++; if (o_misaligned_addr !== 32'h13) begin errors++;
      $display("FAIL mis_addr_sticky: got %h expected 00000013", o_misaligned_addr); end
  endtask

  task automatic test_step_alias();
    logic [31:0] cnt0;
    logic [31:0] pc;
    cnt0 = o_store_count;
    set_in(32'h10, 32'hCAFEF00D, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0);
    commit();
    checks++; if (o_debug_data !== 32'h1234ABCD) begin errors++;
      $display("FAIL step_nowrite: got %h expected 1234abcd", o_debug_data); end
    checks++; if (o_store_count !== cnt0) begin errors++;
      $display("FAIL step_count: got %0d expected %0d", o_store_count, cnt0); end
    set_in(32'(NB) + 32'h10, 32'h0000A5A5, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1);
    commit();
    set_in(32'h10, 32'h0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1);
    pc = 32'h00400123;
    i_pc_to_reg = pc;
    #1;
    checks++; if (o_debug_data !== 32'h0000A5A5) begin errors++;
      $display("FAIL alias_store: got %h expected 0000a5a5", o_debug_data); end
    checks++; if (o_output_mem !== 32'h0) begin errors++;
      $display("FAIL noread_zero: got %h expected 0", o_output_mem); end
    checks++; if (o_pc_to_reg !== pc || o_ALU_res !== 32'h10) begin errors++;
      $display("FAIL passthru: got %h/%h expected %h/00000010", o_pc_to_reg, o_ALU_res, pc); end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [1:0]  s;
    logic        rd, wr;
    logic [31:0] exp;
    logic [9:0]  ctl;
    int          dbg;
    for (int it = 0; it < 400; it++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      s  = 2'($urandom_range(0, 3));
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      set_in(a, $urandom, rd, wr, s, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 7) != 0));
      ctl = 10'($urandom);
      {i_addr_reg_dst, is_RegWrite, is_MemtoReg, is_write_pc, is_stop_pipe} = ctl[8:0];
      i_pc_to_reg = $urandom;
      dbg = $urandom_range(0, DEPTH - 1);
      i_debug_addr = AW'(dbg);
      #1;
      exp = (rd && !mis_m(a, s, rd, wr)) ? load_m(a, s, i_unsigned) : 32'h0;
      checks++; if (o_output_mem !== exp) begin errors++;
        $display("FAIL rnd_load[%0d]: got %h expected %h", it, o_output_mem, exp); end
      checks++; if (o_debug_data !== word_m(dbg)) begin errors++;
        $display("FAIL rnd_debug[%0d]: got %h expected %h", it, o_debug_data, word_m(dbg)); end
      checks++;
      if ({o_addr_reg_dst, os_RegWrite, os_MemtoReg, os_write_pc, os_stop_pipe} !== ctl[8:0]) begin
        errors++;
        $display("FAIL rnd_ctl[%0d]: got %h expected %h", it,
                 {o_addr_reg_dst, os_RegWrite, os_MemtoReg, os_write_pc, os_stop_pipe}, ctl[8:0]);
      end
      commit();
      checks++; if (o_store_count !== cnt_m) begin errors++;
        $display("FAIL rnd_count[%0d]: got %0d expected %0d", it, o_store_count, cnt_m); end
      checks++; if (o_misaligned !== flag_m || o_misaligned_addr !== maddr_m) begin errors++;
        $display("FAIL rnd_mis[%0d]: got %b/%h expected %b/%h", it,
                 o_misaligned, o_misaligned_addr, flag_m, maddr_m); end
    end
  endtask

  initial begin
    rst = 1'b1;
    set_in(32'h0, 32'h0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0);
    i_addr_reg_dst = 5'd0; i_pc_to_reg = 32'h0; is_RegWrite = 1'b0;
    is_MemtoReg = 1'b0; is_write_pc = 1'b0; is_stop_pipe = 1'b0;
    i_debug_addr = '0;
    cnt_m = 0; flag_m = 1'b0; maddr_m = 0;
    for (int i = 0; i < NB; i++) mem_m[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    // give the array known contents (also makes the store count nonzero)
    for (int w = 0; w < DEPTH; w++) begin
      set_in(32'(4 * w), 32'h0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1);
      commit();
    end
    set_in(32'h0, 32'h0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1);
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_misaligned();
    test_step_alias();
    test_random();
    set_in(32'h0, 32'h0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1);
    test_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
